// File: rtl/eiu_pkg.sv
// Shared constants and types for the exception/interrupt unit.
package eiu_pkg;

    localparam int ZCRV_XLEN      = 32;
    localparam int ZCRV_ADDR_SIZE = 32;

    // Synchronous exception cause codes.
    localparam logic [3:0] ZCRV_EXC_IADDR_MIS = 4'd0;
    localparam logic [3:0] ZCRV_EXC_ILLEGAL   = 4'd2;
    localparam logic [3:0] ZCRV_EXC_EBREAK    = 4'd3;
    localparam logic [3:0] ZCRV_EXC_LADDR_MIS = 4'd4;
    localparam logic [3:0] ZCRV_EXC_SADDR_MIS = 4'd6;
    localparam logic [3:0] ZCRV_EXC_ECALL_M   = 4'd11;

    // Machine interrupt cause codes.
    localparam logic [3:0] ZCRV_IRQ_MSI = 4'd3;
    localparam logic [3:0] ZCRV_IRQ_MTI = 4'd7;
    localparam logic [3:0] ZCRV_IRQ_MEI = 4'd11;

    // FSM state encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_WFI   = 2'd2
    } eiu_state_e;

    // Source of the value written to mtval on a trap.
    typedef enum logic [1:0] {
        MTVAL_ZERO    = 2'd0,
        MTVAL_BADADDR = 2'd1,
        MTVAL_INST    = 2'd2
    } mtval_sel_e;

endpackage

// File: rtl/eiu_prio.sv
// Priority encoder: picks one trap source out of the enabled interrupts and
// the synchronous exception flags of the committing instruction.
import eiu_pkg::*;

module eiu_prio (
    input  logic       irq_en,          // global machine interrupt enable
    input  logic [2:0] irq_vec,         // {MEI, MSI, MTI}, already masked by mie
    input  logic       exc_iaddr_mis,
    input  logic       exc_illegal,
    input  logic       exc_ecall,
    input  logic       exc_ebreak,
    input  logic       exc_laddr_mis,
    input  logic       exc_saddr_mis,
    output logic       take,
    output logic       is_irq,
    output logic [3:0] code,
    output mtval_sel_e mtval_sel
);

    // Interrupts first (MEI > MSI > MTI), then exceptions in architectural order.
    always_comb begin
        take      = 1'b1;
        is_irq    = 1'b0;
        code      = 4'd0;
        mtval_sel = MTVAL_ZERO;
        if (irq_en && (irq_vec != 3'b000)) begin
            is_irq = 1'b1;
            if (irq_vec[2])      code = ZCRV_IRQ_MEI;
            else if (irq_vec[1]) code = ZCRV_IRQ_MSI;
            else                 code = ZCRV_IRQ_MTI;
        end else if (exc_iaddr_mis) begin
            code      = ZCRV_EXC_IADDR_MIS;
            mtval_sel = MTVAL_BADADDR;
        end else if (exc_illegal) begin
            code      = ZCRV_EXC_ILLEGAL;
            mtval_sel = MTVAL_INST;
        end else if (exc_ebreak) begin
            code = ZCRV_EXC_EBREAK;
        end else if (exc_ecall) begin
            code = ZCRV_EXC_ECALL_M;
        end else if (exc_laddr_mis) begin
            code      = ZCRV_EXC_LADDR_MIS;
            mtval_sel = MTVAL_BADADDR;
        end else if (exc_saddr_mis) begin
            code      = ZCRV_EXC_SADDR_MIS;
            mtval_sel = MTVAL_BADADDR;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/eiu.sv
// Exception/interrupt unit at the commit stage: trap/mret/wfi sequencing,
// trap values for the CSR file and the fetch redirect.
//
//   state | meaning
//   IDLE  | normal commit, decide trap / mret / wfi / retire
//   REDIR | one cycle after a redirect; commit ignored, no re-trap
//   WFI   | sleeping, commit stalled until a masked interrupt is pending
import eiu_pkg::*;

module eiu (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [31:0] commit_badaddr,
    input  logic        exc_iaddr_mis,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_ebreak,
    input  logic        exc_laddr_mis,
    input  logic        exc_saddr_mis,
    input  logic        is_mret,
    input  logic        is_wfi,
    input  logic        ext_irq,
    input  logic        time_irq,
    input  logic        soft_irq,
    input  logic [31:0] mtvec_r,
    input  logic [31:0] mstatus_r,
    input  logic [31:0] mepc_r,
    input  logic [31:0] mie_r,
    output logic        trap_en,
    output logic        mret_commit,
    output logic [31:0] mepc_from_eiu,
    output logic [31:0] mcause_from_eiu,
    output logic [31:0] mtval_from_eiu,
    output logic        inst_finish,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        commit_stall
);

    eiu_state_e  state_q;
    logic [31:0] wfi_pc_q;
    logic        trap_en_q, mret_commit_q, inst_finish_q, flush_q;
    logic        redirect_valid_q, commit_stall_q;
    logic [31:0] mepc_q, mcause_q, mtval_q, redirect_pc_q;

    logic [2:0]  irq_vec;
    logic        take, is_irq;
    logic [3:0]  code;
    mtval_sel_e  mtval_sel;
    logic [31:0] vec_base, vec_off, vec_target, mcause_d, mtval_d;

    assign irq_vec = {ext_irq & mie_r[11], soft_irq & mie_r[3], time_irq & mie_r[7]};

    eiu_prio u_prio (
        .irq_en        (mstatus_r[3]),
        .irq_vec       (irq_vec),
        .exc_iaddr_mis (exc_iaddr_mis),
        .exc_illegal   (exc_illegal),
        .exc_ecall     (exc_ecall),
        .exc_ebreak    (exc_ebreak),
        .exc_laddr_mis (exc_laddr_mis),
        .exc_saddr_mis (exc_saddr_mis),
        .take          (take),
        .is_irq        (is_irq),
        .code          (code),
        .mtval_sel     (mtval_sel)
    );

    // Trap target, cause and tval; vectored offset only applies to interrupts.
    always_comb begin
        vec_base   = {mtvec_r[31:2], 2'b00};
        vec_off    = (mtvec_r[1:0] == 2'b01 && is_irq) ? {26'd0, code, 2'b00} : 32'd0;
        vec_target = vec_base + vec_off;
        mcause_d   = {is_irq, 27'd0, code};
        case (mtval_sel)
            MTVAL_BADADDR: mtval_d = commit_badaddr;
            MTVAL_INST:    mtval_d = commit_inst;
            default:       mtval_d = 32'd0;
        endcase
    end

    // Control FSM with registered pulse and value outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            wfi_pc_q         <= 32'd0;
            trap_en_q        <= 1'b0;
            mret_commit_q    <= 1'b0;
            inst_finish_q    <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            commit_stall_q   <= 1'b0;
            mepc_q           <= 32'd0;
            mcause_q         <= 32'd0;
            mtval_q          <= 32'd0;
            redirect_pc_q    <= 32'd0;
        end else begin
            trap_en_q        <= 1'b0;
            mret_commit_q    <= 1'b0;
            inst_finish_q    <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            commit_stall_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (commit_valid) begin
                        if (take) begin
                            trap_en_q        <= 1'b1;
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= vec_target;
                            mepc_q           <= commit_pc;
                            mcause_q         <= mcause_d;
                            mtval_q          <= mtval_d;
                            state_q          <= ST_REDIR;
                        end else if (is_mret) begin
                            mret_commit_q    <= 1'b1;
                            inst_finish_q    <= 1'b1;
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= mepc_r;
                            state_q          <= ST_REDIR;
                        end else if (is_wfi) begin
                            inst_finish_q  <= 1'b1;
                            wfi_pc_q       <= commit_pc + 32'd4;
                            commit_stall_q <= 1'b1;
                            state_q        <= ST_WFI;
                        end else begin
                            inst_finish_q <= 1'b1;
                        end
                    end
                end
                ST_REDIR: begin
                    state_q <= ST_IDLE;
                end
                ST_WFI: begin
                    // Wake ignores the global enable; it only decides whether we trap.
                    if (irq_vec != 3'b000) begin
                        if (mstatus_r[3]) begin
                            trap_en_q        <= 1'b1;
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= vec_target;
                            mepc_q           <= wfi_pc_q;
                            mcause_q         <= mcause_d;
                            mtval_q          <= 32'd0;
                            state_q          <= ST_REDIR;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        commit_stall_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign trap_en         = trap_en_q;
    assign mret_commit     = mret_commit_q;
    assign inst_finish     = inst_finish_q;
    assign flush           = flush_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign commit_stall    = commit_stall_q;
    assign mepc_from_eiu   = mepc_q;
    assign mcause_from_eiu = mcause_q;
    assign mtval_from_eiu  = mtval_q;

    // Only a few CSR bits matter to this unit.
    logic unused_csr_bits;
    assign unused_csr_bits = ^{mstatus_r[31:4], mstatus_r[2:0], mie_r[31:12],
                               mie_r[10:8], mie_r[6:4], mie_r[2:0]};

endmodule

// File: tb/tb_eiu.sv
// Directed self-checking bench for the exception/interrupt unit.
`timescale 1ns/1ps
module tb_eiu;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst, commit_badaddr;
    logic        exc_iaddr_mis, exc_illegal, exc_ecall, exc_ebreak, exc_laddr_mis, exc_saddr_mis;
    logic        is_mret, is_wfi, ext_irq, time_irq, soft_irq;
    logic [31:0] mtvec_r, mstatus_r, mepc_r, mie_r;
    logic        trap_en, mret_commit, inst_finish, flush, redirect_valid, commit_stall;
    logic [31:0] mepc_from_eiu, mcause_from_eiu, mtval_from_eiu, redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eiu dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_inst(commit_inst), .commit_badaddr(commit_badaddr),
        .exc_iaddr_mis(exc_iaddr_mis), .exc_illegal(exc_illegal), .exc_ecall(exc_ecall),
        .exc_ebreak(exc_ebreak), .exc_laddr_mis(exc_laddr_mis), .exc_saddr_mis(exc_saddr_mis),
        .is_mret(is_mret), .is_wfi(is_wfi), .ext_irq(ext_irq), .time_irq(time_irq),
        .soft_irq(soft_irq), .mtvec_r(mtvec_r), .mstatus_r(mstatus_r), .mepc_r(mepc_r),
        .mie_r(mie_r), .trap_en(trap_en), .mret_commit(mret_commit),
        .mepc_from_eiu(mepc_from_eiu), .mcause_from_eiu(mcause_from_eiu),
        .mtval_from_eiu(mtval_from_eiu), .inst_finish(inst_finish), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .commit_stall(commit_stall)
    );

    // Advance one cycle; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        commit_valid = 0; commit_pc = 0; commit_inst = 0; commit_badaddr = 0;
        exc_iaddr_mis = 0; exc_illegal = 0; exc_ecall = 0; exc_ebreak = 0;
        exc_laddr_mis = 0; exc_saddr_mis = 0; is_mret = 0; is_wfi = 0;
        ext_irq = 0; time_irq = 0; soft_irq = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_commit();
        mtvec_r = 0; mstatus_r = 0; mepc_r = 0; mie_r = 0;
        tick(); tick();
        n_checks++; if ({trap_en, mret_commit, inst_finish, flush, redirect_valid, commit_stall} !== 6'b0) begin
            $display("FAIL reset_pulses got %b exp 000000", {trap_en, mret_commit, inst_finish, flush, redirect_valid, commit_stall}); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h0) begin $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); n_fail++; end
        n_checks++; if ({mepc_from_eiu, mcause_from_eiu, mtval_from_eiu} !== 96'h0) begin
            $display("FAIL reset_trapvals got %h %h %h exp 0", mepc_from_eiu, mcause_from_eiu, mtval_from_eiu); n_fail++; end
        rst = 0;
        tick();
    endtask

    task automatic test_illegal();
        mtvec_r = 32'h100; mstatus_r = 0;
        commit_valid = 1; commit_pc = 32'h40; commit_inst = 32'hFFFF_FFFF; exc_illegal = 1;
        tick();
        clear_commit();
        n_checks++; if ({trap_en, flush, redirect_valid, inst_finish, mret_commit} !== 5'b11100) begin
            $display("FAIL illegal_pulses got %b exp 11100", {trap_en, flush, redirect_valid, inst_finish, mret_commit}); n_fail++; end
        n_checks++; if (mcause_from_eiu !== 32'h2) begin $display("FAIL illegal_mcause got %h exp 2", mcause_from_eiu); n_fail++; end
        n_checks++; if (mepc_from_eiu !== 32'h40) begin $display("FAIL illegal_mepc got %h exp 40", mepc_from_eiu); n_fail++; end
        n_checks++; if (mtval_from_eiu !== 32'hFFFF_FFFF) begin $display("FAIL illegal_mtval got %h exp ffffffff", mtval_from_eiu); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h100) begin $display("FAIL illegal_redirect got %h exp 100", redirect_pc); n_fail++; end
        tick();
        n_checks++; if ({trap_en, flush} !== 2'b00) begin $display("FAIL illegal_pulse_width got %b exp 00", {trap_en, flush}); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h100) begin $display("FAIL illegal_redirect_hold got %h exp 100", redirect_pc); n_fail++; end
    endtask

    task automatic test_vec_timer();
        mtvec_r = 32'h201; mstatus_r = 32'h8; mie_r = 32'h80;
        commit_valid = 1; commit_pc = 32'h80; exc_ecall = 1; time_irq = 1;
        tick();
        clear_commit();
        n_checks++; if (trap_en !== 1'b1) begin $display("FAIL vtimer_trap got %b exp 1", trap_en); n_fail++; end
        n_checks++; if (mcause_from_eiu !== 32'h8000_0007) begin $display("FAIL vtimer_mcause got %h exp 80000007", mcause_from_eiu); n_fail++; end
        n_checks++; if (mepc_from_eiu !== 32'h80) begin $display("FAIL vtimer_mepc got %h exp 80", mepc_from_eiu); n_fail++; end
        n_checks++; if (mtval_from_eiu !== 32'h0) begin $display("FAIL vtimer_mtval got %h exp 0", mtval_from_eiu); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h21C) begin $display("FAIL vtimer_redirect got %h exp 21c", redirect_pc); n_fail++; end
        tick();
    endtask

    task automatic test_irq_prio();
        mtvec_r = 32'h201; mstatus_r = 32'h8; mie_r = 32'h888;
        commit_valid = 1; commit_pc = 32'h90; ext_irq = 1; time_irq = 1; soft_irq = 1;
        tick();
        n_checks++; if (mcause_from_eiu !== 32'h8000_000B) begin $display("FAIL prio_mcause got %h exp 8000000b", mcause_from_eiu); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h22C) begin $display("FAIL prio_redirect got %h exp 22c", redirect_pc); n_fail++; end
        // REDIR cycle: commit_valid and irqs still up, no second trap allowed.
        tick();
        n_checks++; if ({trap_en, inst_finish, flush} !== 3'b000) begin
            $display("FAIL prio_no_retrap got %b exp 000", {trap_en, inst_finish, flush}); n_fail++; end
        // Soft beats timer once MEI drops.
        ext_irq = 0;
        tick();
        n_checks++; if (mcause_from_eiu !== 32'h8000_0003 || trap_en !== 1'b1) begin
            $display("FAIL prio_msi got %h/%b exp 80000003/1", mcause_from_eiu, trap_en); n_fail++; end
        clear_commit();
        tick();
    endtask

    task automatic test_mret();
        mstatus_r = 0; mie_r = 0; mepc_r = 32'h1234;
        commit_valid = 1; commit_pc = 32'hA0; is_mret = 1;
        tick();
        clear_commit();
        n_checks++; if ({mret_commit, inst_finish, flush, redirect_valid, trap_en} !== 5'b11110) begin
            $display("FAIL mret_pulses got %b exp 11110", {mret_commit, inst_finish, flush, redirect_valid, trap_en}); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h1234) begin $display("FAIL mret_redirect got %h exp 1234", redirect_pc); n_fail++; end
        tick();
        n_checks++; if (mret_commit !== 1'b0) begin $display("FAIL mret_pulse_width got %b exp 0", mret_commit); n_fail++; end
    endtask

    task automatic test_exc_order();
        // {iaddr, illegal, ebreak, ecall, laddr, saddr}, expected cause, expected mtval
        logic [5:0]  flags [6] = '{6'b110000, 6'b011000, 6'b001100, 6'b000110, 6'b000011, 6'b000001};
        logic [31:0] ecause[6] = '{32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        logic [31:0] etval [6] = '{32'hBAD0_0001, 32'h0000_0073, 32'h0, 32'h0, 32'hBAD0_0001, 32'hBAD0_0001};
        mtvec_r = 32'h201; mstatus_r = 32'h8; mie_r = 32'h888;
        for (int i = 0; i < 6; i++) begin
            commit_valid = 1; commit_pc = 32'h500 + 32'(i * 4); commit_inst = 32'h73; commit_badaddr = 32'hBAD0_0001;
            {exc_iaddr_mis, exc_illegal, exc_ebreak, exc_ecall, exc_laddr_mis, exc_saddr_mis} = flags[i];
            tick();
            clear_commit();
            n_checks++; if (mcause_from_eiu !== ecause[i] || mtval_from_eiu !== etval[i] || trap_en !== 1'b1) begin
                $display("FAIL exc_order[%0d] got cause %h tval %h trap %b exp %h %h 1", i, mcause_from_eiu, mtval_from_eiu, trap_en, ecause[i], etval[i]); n_fail++; end
            n_checks++; if (redirect_pc !== 32'h200 || mepc_from_eiu !== 32'h500 + 32'(i * 4)) begin
                $display("FAIL exc_target[%0d] got %h mepc %h exp 200 %h", i, redirect_pc, mepc_from_eiu, 32'h500 + 32'(i * 4)); n_fail++; end
            tick();
        end
    endtask

    task automatic test_retire_and_mask();
        // Pending enabled irq but global MIE off: plain retire, redirect_pc holds.
        mtvec_r = 32'h201; mstatus_r = 0; mie_r = 32'h800;
        commit_valid = 1; commit_pc = 32'h600; ext_irq = 1;
        tick();
        clear_commit();
        n_checks++; if ({inst_finish, trap_en, flush, redirect_valid} !== 4'b1000) begin
            $display("FAIL retire_pulses got %b exp 1000", {inst_finish, trap_en, flush, redirect_valid}); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h200) begin $display("FAIL retire_redirect_hold got %h exp 200", redirect_pc); n_fail++; end
        tick();
        n_checks++; if (inst_finish !== 1'b0) begin $display("FAIL retire_idle got %b exp 0", inst_finish); n_fail++; end
    endtask

    task automatic test_vector_modes();
        // Mode 1 with wrap past 2^32; mode 3 behaves as direct.
        mstatus_r = 32'h8; mie_r = 32'h80;
        mtvec_r = 32'hFFFF_FFFD; commit_valid = 1; commit_pc = 32'h700; time_irq = 1;
        tick();
        n_checks++; if (redirect_pc !== 32'h18) begin $display("FAIL vec_wrap got %h exp 18", redirect_pc); n_fail++; end
        clear_commit(); tick();
        mtvec_r = 32'h203; commit_valid = 1; commit_pc = 32'h704; time_irq = 1;
        tick();
        n_checks++; if (redirect_pc !== 32'h200) begin $display("FAIL vec_mode3 got %h exp 200", redirect_pc); n_fail++; end
        clear_commit(); tick();
    endtask

    task automatic test_wfi_mie0();
        mtvec_r = 32'h100; mstatus_r = 0; mie_r = 32'h800;
        commit_valid = 1; commit_pc = 32'h300; is_wfi = 1;
        tick();
        clear_commit();
        n_checks++; if ({inst_finish, commit_stall, flush, trap_en} !== 4'b1100) begin
            $display("FAIL wfi0_entry got %b exp 1100", {inst_finish, commit_stall, flush, trap_en}); n_fail++; end
        // Commit traffic is ignored while asleep.
        commit_valid = 1; commit_pc = 32'h304; exc_illegal = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({commit_stall, trap_en, inst_finish} !== 3'b100) begin
                $display("FAIL wfi0_sleep[%0d] got %b exp 100", i, {commit_stall, trap_en, inst_finish}); n_fail++; end
        end
        clear_commit();
        ext_irq = 1;
        tick();
        ext_irq = 0;
        n_checks++; if ({commit_stall, trap_en, flush} !== 3'b000) begin
            $display("FAIL wfi0_wake got %b exp 000", {commit_stall, trap_en, flush}); n_fail++; end
        commit_valid = 1; commit_pc = 32'h304;
        tick();
        clear_commit();
        n_checks++; if (inst_finish !== 1'b1) begin $display("FAIL wfi0_back_idle got %b exp 1", inst_finish); n_fail++; end
    endtask

    task automatic test_wfi_mie1();
        mtvec_r = 32'h100; mstatus_r = 32'h8; mie_r = 32'h800;
        commit_valid = 1; commit_pc = 32'h300; is_wfi = 1;
        tick();
        clear_commit();
        tick(); tick();
        n_checks++; if (commit_stall !== 1'b1) begin $display("FAIL wfi1_sleep got %b exp 1", commit_stall); n_fail++; end
        ext_irq = 1;
        tick();
        ext_irq = 0;
        n_checks++; if ({trap_en, commit_stall, flush} !== 3'b101) begin
            $display("FAIL wfi1_wake got %b exp 101", {trap_en, commit_stall, flush}); n_fail++; end
        n_checks++; if (mepc_from_eiu !== 32'h304 || mcause_from_eiu !== 32'h8000_000B) begin
            $display("FAIL wfi1_vals got mepc %h cause %h exp 304 8000000b", mepc_from_eiu, mcause_from_eiu); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h100) begin $display("FAIL wfi1_redirect got %h exp 100", redirect_pc); n_fail++; end
        tick();
    endtask

    task automatic test_reset_in_wfi();
        mstatus_r = 0; mie_r = 0;
        commit_valid = 1; commit_pc = 32'h400; is_wfi = 1;
        tick();
        clear_commit();
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if ({trap_en, mret_commit, inst_finish, flush, redirect_valid, commit_stall} !== 6'b0) begin
            $display("FAIL rstwfi_pulses got %b exp 000000", {trap_en, mret_commit, inst_finish, flush, redirect_valid, commit_stall}); n_fail++; end
        n_checks++; if (redirect_pc !== 32'h0 || mepc_from_eiu !== 32'h0) begin
            $display("FAIL rstwfi_vals got %h %h exp 0 0", redirect_pc, mepc_from_eiu); n_fail++; end
        // In IDLE a plain commit retires straight away.
        commit_valid = 1; commit_pc = 32'h408;
        tick();
        clear_commit();
        n_checks++; if ({inst_finish, commit_stall} !== 2'b10) begin
            $display("FAIL rstwfi_idle got %b exp 10", {inst_finish, commit_stall}); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_vec_timer();
        test_irq_prio();
        test_mret();
        test_exc_order();
        test_retire_and_mask();
        test_vector_modes();
        test_wfi_mie0();
        test_wfi_mie1();
        test_reset_in_wfi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
